// File: rtl/sort_controller.sv
`default_nettype none
// ============================================================================
// Module   : sort_controller
// Purpose  : Sequencing FSM for the in-place ascending exchange-sort datapath.
//            Define SORT_STATS_EN to add compare/swap statistics outputs.
// Revision : 1.0 - initial release
// ============================================================================
module sort_controller #(
    parameter int K = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       mem_own,
    input  logic       AgtB,
    input  logic       zi,
    input  logic       zj,
    output logic       EA,
    output logic       EB,
    output logic       Li,
    output logic       Ei,
    output logic       Lj,
    output logic       Ej,
    output logic       Csel,
    output logic       WE,
    output logic       Bout
`ifdef SORT_STATS_EN
    ,
    output logic [5:0] cmp_count,
    output logic [5:0] swap_count
`endif
);

    if (K < 2 || K > 8) begin : g_k_range_check
        $error("sort_controller: K must be in 2..8");
    end

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_INIT     = 4'd1,
        S_LOAD_A   = 4'd2,
        S_LOAD_B   = 4'd3,
        S_CMP      = 4'd4,
        S_SWAP1    = 4'd5,
        S_SWAP2    = 4'd6,
        S_RELOAD_A = 4'd7,
        S_NEXT_J   = 4'd8,
        S_NEXT_I   = 4'd9,
        S_DONE     = 4'd10
    } state_t;

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        done   = 1'b0;
        EA     = 1'b0;
        EB     = 1'b0;
        Li     = 1'b0;
        Ei     = 1'b0;
        Lj     = 1'b0;
        Ej     = 1'b0;
        Csel   = 1'b0;
        WE     = 1'b0;
        Bout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_INIT;
                end
            end
            S_INIT: begin
                Li     = 1'b1;
                w_next = S_LOAD_A;
            end
            S_LOAD_A: begin
                EA     = 1'b1;
                Lj     = 1'b1;
                w_next = S_LOAD_B;
            end
            S_LOAD_B: begin
                Csel   = 1'b1;
                EB     = 1'b1;
                w_next = S_CMP;
            end
            S_CMP: begin
                w_next = AgtB ? S_SWAP1 : S_NEXT_J;
            end
            // Swap writes mem[i] <= B then mem[j] <= A; A is then refreshed
            // from mem[i] so later comparisons use the new minimum.
            S_SWAP1: begin
                Bout   = 1'b1;
                WE     = 1'b1;
                w_next = S_SWAP2;
            end
            S_SWAP2: begin
                Csel   = 1'b1;
                WE     = 1'b1;
                w_next = S_RELOAD_A;
            end
            S_RELOAD_A: begin
                EA     = 1'b1;
                w_next = S_NEXT_J;
            end
            S_NEXT_J: begin
                if (zj) begin
                    w_next = S_NEXT_I;
                end else begin
                    Ej     = 1'b1;
                    w_next = S_LOAD_B;
                end
            end
            S_NEXT_I: begin
                if (zi) begin
                    w_next = S_DONE;
                end else begin
                    Ei     = 1'b1;
                    w_next = S_LOAD_A;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign busy    = (r_state != S_IDLE);
    assign mem_own = busy;

`ifdef SORT_STATS_EN
    logic [5:0] r_cmp_count;
    logic [5:0] r_swap_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cmp_count  <= 6'd0;
            r_swap_count <= 6'd0;
        end else if (r_state == S_IDLE && start) begin
            r_cmp_count  <= 6'd0;
            r_swap_count <= 6'd0;
        end else begin
            if (r_state == S_CMP) begin
                r_cmp_count <= r_cmp_count + 6'd1;
            end
            if (r_state == S_SWAP1) begin
                r_swap_count <= r_swap_count + 6'd1;
            end
        end
    end

    assign cmp_count  = r_cmp_count;
    assign swap_count = r_swap_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sort_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sort_controller
// Purpose  : Scoreboard bench for sort_controller with a behavioural datapath.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sort_controller;

    localparam int K = 8;

    typedef logic [K-1:0][7:0] vec_t;
    typedef struct {
        int   cycles;
        int   swaps;
        vec_t mem;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic busy, done, mem_own, AgtB, zi, zj;
    logic EA, EB, Li, Ei, Lj, Ej, Csel, WE, Bout;
`ifdef SORT_STATS_EN
    logic [5:0] cmp_count, swap_count;
`endif

    sort_controller #(.K(K)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .mem_own (mem_own),
        .AgtB    (AgtB),
        .zi      (zi),
        .zj      (zj),
        .EA      (EA),
        .EB      (EB),
        .Li      (Li),
        .Ei      (Ei),
        .Lj      (Lj),
        .Ej      (Ej),
        .Csel    (Csel),
        .WE      (WE),
        .Bout    (Bout)
`ifdef SORT_STATS_EN
        ,
        .cmp_count  (cmp_count),
        .swap_count (swap_count)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural datapath: A/B registers, i/j counters, K-entry memory.
    vec_t       r_mem;
    vec_t       ld_vec;
    logic       ld = 1'b0;
    logic [7:0] r_a = 8'd0;
    logic [7:0] r_b = 8'd0;
    logic [2:0] r_i = 3'd0;
    logic [2:0] r_j = 3'd0;
    logic [2:0] w_addr;

    assign w_addr = Csel ? r_j : r_i;
    assign AgtB   = (r_a > r_b);
    assign zi     = (r_i == 3'(K - 2));
    assign zj     = (r_j == 3'(K - 1));

    always @(posedge clk) begin
        if (ld) r_mem <= ld_vec;
        else if (WE) r_mem[w_addr] <= Bout ? r_b : r_a;
        if (EA) r_a <= r_mem[w_addr];
        if (EB) r_b <= r_mem[w_addr];
        if (Li) r_i <= 3'd0;
        else if (Ei) r_i <= r_i + 3'd1;
        if (Lj) r_j <= r_i + 3'd1;
        else if (Ej) r_j <= r_j + 3'd1;
    end

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: per-cycle invariants and scoreboard pop on every done pulse.
    int   bcnt = 0;
    int   wecnt = 0;
    logic prev_done = 1'b0;
    exp_t e;

    always @(negedge clk) begin
        if (!rst) begin
            bcnt      = 0;
            wecnt     = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) bcnt++;
            if (WE) wecnt++;
            chk("we_vs_load", 64'(WE & (EA | EB)), 64'd0);
            chk("li_ei_excl", 64'(Li & Ei), 64'd0);
            chk("lj_ej_excl", 64'(Lj & Ej), 64'd0);
            chk("mem_own_eq_busy", 64'(mem_own), 64'(busy));
            if (done) begin
                chk("done_single_pulse", 64'(prev_done), 64'd0);
                chk("done_busy", 64'(busy), 64'd1);
                chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("busy_cycles", 64'(bcnt), 64'(e.cycles));
                    chk("write_count", 64'(wecnt), 64'(2 * e.swaps));
                    chk("final_mem", r_mem, e.mem);
`ifdef SORT_STATS_EN
                    chk("cmp_count", 64'(cmp_count), 64'd28);
                    chk("swap_count", 64'(swap_count), 64'(e.swaps));
`endif
                end
                bcnt  = 0;
                wecnt = 0;
            end
            prev_done = done;
        end
    end

    task automatic load(input vec_t v);
        ld_vec = v;
        ld     = 1'b1;
        @(negedge clk);
        ld     = 1'b0;
    endtask

    task automatic expect_sort(input vec_t m, input int cyc, input int sw);
        exp_t x;
        x.cycles = cyc;
        x.swaps  = sw;
        x.mem    = m;
        sb.push_back(x);
    endtask

    // Returns at the negedge where done is seen (start left at 'hold').
    task automatic wait_done(input int glitch, input logic hold);
        bit got = 0;
        for (int c = 1; c <= 400; c++) begin
            if (done) begin
                got = 1;
                break;
            end
            start = hold | (c == glitch);
            @(negedge clk);
        end
        chk("done_timeout", 64'(got), 64'd1);
    endtask

    task automatic run(input vec_t init, input vec_t m, input int cyc, input int sw, input int glitch);
        load(init);
        expect_sort(m, cyc, sw);
        start = 1'b1;
        @(negedge clk);
        wait_done(glitch, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    localparam vec_t V_ASC  = 64'h0706050403020100;
    localparam vec_t V_DESC = 64'h0001020304050607;
    localparam vec_t V_DUP  = {8'd1, 8'd9, 8'd0, 8'd9, 8'd3, 8'd3, 8'd5, 8'd5};
    localparam vec_t V_DUPS = {8'd9, 8'd9, 8'd5, 8'd5, 8'd3, 8'd3, 8'd1, 8'd0};

    initial begin
        // Reset with start held high: everything must be quiet.
        rst   = 1'b0;
        start = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("reset_outputs", 64'({busy, done, mem_own, EA, EB, Li, Ei, Lj, Ej, Csel, WE, Bout}), 64'd0);
        end
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_after_reset", 64'(busy), 64'd0);
        end

        run(V_ASC,  V_ASC,  100, 0,  -1);
        run(V_DESC, V_ASC,  184, 28, -1);
        run(V_DUP,  V_DUPS, 124, 8,  -1);

        // Start pulsed while busy must be ignored.
        run(V_DESC, V_ASC, 184, 28, 10);
        repeat (5) begin
            @(negedge clk);
            chk("glitch_no_relaunch", 64'(busy), 64'd0);
        end

        // Start held through DONE re-launches straight from IDLE.
        load(V_DESC);
        expect_sort(V_ASC, 184, 28);
        expect_sort(V_ASC, 100, 0);
        start = 1'b1;
        @(negedge clk);
        wait_done(-1, 1'b1);
        @(negedge clk);
        chk("held_start_idle", 64'(busy), 64'd0);
        @(negedge clk);
        chk("held_start_relaunch", 64'(busy), 64'd1);
        wait_done(-1, 1'b0);
        repeat (2) @(negedge clk);

        // Reset during the first SWAP1 abandons the sort.
        load(V_DESC);
        expect_sort(V_ASC, 184, 28);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 50 && !(WE && !Csel); c++) @(negedge clk);
        chk("swap1_reached", 64'(WE & ~Csel), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_we", 64'(WE), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_mem0_written", 64'(r_mem[0]), 64'd6);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_idle", 64'(busy), 64'd0);
        run(V_DESC, V_ASC, 184, 28, -1);

        repeat (5) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
